// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with a data/control payload split, flush,
// an optional 2-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_hs #(
  parameter int DATA_W   = 64*4+5,
  parameter int CTRL_W   = 11,
  parameter int SKID     = 1,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [CTRL_W-1:0]   in_ctrl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [STALL_CW-1:0] stall_cycles
);

  logic              adv;
  logic              in_xfer;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign adv     = !out_valid || out_ready;
  // An input presented during flush is discarded even if the handshake completes.
  assign in_xfer = in_valid && in_ready && !flush;

  generate
    if (SKID != 0) begin : g_skid
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          skid_valid <= 1'b0;
          skid_data  <= '0;
          skid_ctrl  <= '0;
        end else if (flush || adv) begin
          skid_valid <= 1'b0;
        end else if (in_xfer) begin
          skid_valid <= 1'b1;
          skid_data  <= in_data;
          skid_ctrl  <= in_ctrl;
        end
      end

      // Depends only on state and reset, so upstream never sees out_ready combinationally.
      assign in_ready = !skid_valid && !reset;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
      assign in_ready   = adv && !reset;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (adv) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
        out_ctrl  <= skid_ctrl;
      end else if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
        out_ctrl  <= in_ctrl;
      end else begin
        // Bubble: control cleared so it acts as a NOP, data left untouched.
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed self-checking bench for pipe_stage_hs: skid and no-skid variants plus
// a narrow-counter variant for saturation and asynchronous reset.
module tb_pipe_stage_hs;

  localparam int AW = 261;
  localparam int AC = 11;
  localparam int BW = 16;
  localparam int BC = 11;
  localparam int CW = 8;
  localparam int CC = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [AW-1:0] a_in_data, a_out_data;
  logic [AC-1:0] a_in_ctrl, a_out_ctrl;
  logic [15:0]   a_stall;

  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [BW-1:0] b_in_data, b_out_data;
  logic [BC-1:0] b_in_ctrl, b_out_ctrl;
  logic [15:0]   b_stall;

  logic          c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [CW-1:0] c_in_data, c_out_data;
  logic [CC-1:0] c_in_ctrl, c_out_ctrl;
  logic [3:0]    c_stall;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  pipe_stage_hs #(.DATA_W(AW), .CTRL_W(AC), .SKID(1), .STALL_CW(16)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .stall_cycles(a_stall)
  );

  pipe_stage_hs #(.DATA_W(BW), .CTRL_W(BC), .SKID(0), .STALL_CW(16)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .stall_cycles(b_stall)
  );

  pipe_stage_hs #(.DATA_W(CW), .CTRL_W(CC), .SKID(1), .STALL_CW(4)) dut_c (
    .clk(clk), .reset(reset), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_ctrl(c_in_ctrl),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_ctrl(c_out_ctrl),
    .stall_cycles(c_stall)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_a_valid: got %0b expected 0", a_out_valid); end
    n_checks++; if (a_out_data !== '0) begin n_fails++; $display("FAIL reset_a_data: got %0h expected 0", a_out_data); end
    n_checks++; if (a_out_ctrl !== '0) begin n_fails++; $display("FAIL reset_a_ctrl: got %0h expected 0", a_out_ctrl); end
    n_checks++; if (a_stall !== 16'd0) begin n_fails++; $display("FAIL reset_a_stall: got %0d expected 0", a_stall); end
    n_checks++; if (a_in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_a_in_ready: got %0b expected 0", a_in_ready); end
    n_checks++; if (b_in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_b_in_ready: got %0b expected 0", b_in_ready); end
    n_checks++; if (c_in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_c_in_ready: got %0b expected 0", c_in_ready); end
    tick;
    tick;
    reset = 1'b0;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fails++; $display("FAIL post_reset_a_in_ready: got %0b expected 1", a_in_ready); end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fails++; $display("FAIL post_reset_b_in_ready: got %0b expected 1", b_in_ready); end
  endtask

  task automatic test_stream;
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = AW'(i);
      a_in_ctrl  = AC'(i);
      tick;
      n_checks++; if (a_out_valid !== 1'b1) begin n_fails++; $display("FAIL stream_valid[%0d]: got %0b expected 1", i, a_out_valid); end
      n_checks++; if (a_out_data !== AW'(i)) begin n_fails++; $display("FAIL stream_data[%0d]: got %0h expected %0h", i, a_out_data, i); end
      n_checks++; if (a_out_ctrl !== AC'(i)) begin n_fails++; $display("FAIL stream_ctrl[%0d]: got %0h expected %0h", i, a_out_ctrl, i); end
      n_checks++; if (a_in_ready !== 1'b1) begin n_fails++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, a_in_ready); end
    end
    a_in_valid = 1'b0;
    tick;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fails++; $display("FAIL stream_drain_valid: got %0b expected 0", a_out_valid); end
    n_checks++; if (a_out_data !== AW'(8)) begin n_fails++; $display("FAIL stream_drain_data: got %0h expected 8", a_out_data); end
    n_checks++; if (a_stall !== 16'd0) begin n_fails++; $display("FAIL stream_stall: got %0d expected 0", a_stall); end
  endtask

  task automatic test_back_to_back;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = AW'(1); a_in_ctrl = AC'(1);
    tick;
    n_checks++; if (a_out_data !== AW'(1)) begin n_fails++; $display("FAIL bp_first: got %0h expected 1", a_out_data); end
    a_in_data = AW'(2); a_in_ctrl = AC'(2);
    tick;
    n_checks++; if (a_out_data !== AW'(2)) begin n_fails++; $display("FAIL bp_second: got %0h expected 2", a_out_data); end
    a_in_data = AW'(3); a_in_ctrl = AC'(3);
    a_out_ready = 1'b0;
    tick;
    n_checks++; if (a_out_data !== AW'(2)) begin n_fails++; $display("FAIL bp_hold1: got %0h expected 2", a_out_data); end
    n_checks++; if (a_in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_in_ready1: got %0b expected 0", a_in_ready); end
    n_checks++; if (a_stall !== 16'd1) begin n_fails++; $display("FAIL bp_stall1: got %0d expected 1", a_stall); end
    a_in_data = AW'(4); a_in_ctrl = AC'(4);
    tick;
    tick;
    n_checks++; if (a_out_data !== AW'(2)) begin n_fails++; $display("FAIL bp_hold3: got %0h expected 2", a_out_data); end
    n_checks++; if (a_out_ctrl !== AC'(2)) begin n_fails++; $display("FAIL bp_hold3_ctrl: got %0h expected 2", a_out_ctrl); end
    n_checks++; if (a_in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_in_ready3: got %0b expected 0", a_in_ready); end
    n_checks++; if (a_stall !== 16'd3) begin n_fails++; $display("FAIL bp_stall3: got %0d expected 3", a_stall); end
    a_out_ready = 1'b1;
    tick;
    n_checks++; if (a_out_data !== AW'(3)) begin n_fails++; $display("FAIL bp_release_skid: got %0h expected 3", a_out_data); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fails++; $display("FAIL bp_release_ready: got %0b expected 1", a_in_ready); end
    tick;
    n_checks++; if (a_out_data !== AW'(4)) begin n_fails++; $display("FAIL bp_release_next: got %0h expected 4", a_out_data); end
    n_checks++; if (a_out_valid !== 1'b1) begin n_fails++; $display("FAIL bp_release_valid: got %0b expected 1", a_out_valid); end
    a_in_valid = 1'b0;
    tick;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fails++; $display("FAIL bp_no_dup: got %0b expected 0", a_out_valid); end
    n_checks++; if (a_stall !== 16'd3) begin n_fails++; $display("FAIL bp_stall_final: got %0d expected 3", a_stall); end
  endtask

  task automatic test_flush;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = AW'(5); a_in_ctrl = AC'(5);
    tick;
    a_out_ready = 1'b0;
    a_in_data   = AW'(6); a_in_ctrl = AC'(6);
    tick;
    n_checks++; if (a_out_data !== AW'(5)) begin n_fails++; $display("FAIL flush_main: got %0h expected 5", a_out_data); end
    n_checks++; if (a_in_ready !== 1'b0) begin n_fails++; $display("FAIL flush_skid_full: got %0b expected 0", a_in_ready); end
    a_flush   = 1'b1;
    a_in_data = AW'(7); a_in_ctrl = AC'(7);
    tick;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fails++; $display("FAIL flush_valid: got %0b expected 0", a_out_valid); end
    n_checks++; if (a_out_ctrl !== '0) begin n_fails++; $display("FAIL flush_ctrl: got %0h expected 0", a_out_ctrl); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fails++; $display("FAIL flush_in_ready: got %0b expected 1", a_in_ready); end
    n_checks++; if (a_stall !== 16'd4) begin n_fails++; $display("FAIL flush_stall: got %0d expected 4", a_stall); end
    a_flush     = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++; if (a_out_valid !== 1'b0) begin n_fails++; $display("FAIL flush_no_leak[%0d]: got %0b expected 0 data %0h", i, a_out_valid, a_out_data); end
    end
    n_checks++; if (a_out_data !== AW'(5)) begin n_fails++; $display("FAIL flush_data_hold: got %0h expected 5", a_out_data); end
  endtask

  task automatic test_bubble;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = AW'(9); a_in_ctrl = 11'h7FF;
    tick;
    n_checks++; if (a_out_ctrl !== 11'h7FF) begin n_fails++; $display("FAIL bubble_ctrl_live: got %0h expected 7ff", a_out_ctrl); end
    a_in_valid = 1'b0;
    a_in_data  = AW'(8'hAA); a_in_ctrl = 11'h123;
    tick;
    n_checks++; if (a_out_ctrl !== '0) begin n_fails++; $display("FAIL bubble_ctrl_nop: got %0h expected 0", a_out_ctrl); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fails++; $display("FAIL bubble_valid: got %0b expected 0", a_out_valid); end
    tick;
    n_checks++; if (a_out_data !== AW'(9)) begin n_fails++; $display("FAIL bubble_data_hold: got %0h expected 9", a_out_data); end
  endtask

  task automatic test_skid0;
    n_checks++; if (b_in_ready !== 1'b1) begin n_fails++; $display("FAIL s0_empty_ready: got %0b expected 1", b_in_ready); end
    b_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = BW'(i); b_in_ctrl = BC'(i);
      tick;
      n_checks++; if (b_out_data !== BW'(i)) begin n_fails++; $display("FAIL s0_stream[%0d]: got %0h expected %0h", i, b_out_data, i); end
    end
    b_in_data   = BW'(5); b_in_ctrl = BC'(5);
    b_out_ready = 1'b0;
    #1;
    n_checks++; if (b_in_ready !== 1'b0) begin n_fails++; $display("FAIL s0_comb_ready_low: got %0b expected 0", b_in_ready); end
    tick;
    n_checks++; if (b_out_data !== BW'(4)) begin n_fails++; $display("FAIL s0_hold: got %0h expected 4", b_out_data); end
    b_out_ready = 1'b1;
    #1;
    n_checks++; if (b_in_ready !== 1'b1) begin n_fails++; $display("FAIL s0_comb_ready_high: got %0b expected 1", b_in_ready); end
    tick;
    n_checks++; if (b_out_data !== BW'(5)) begin n_fails++; $display("FAIL s0_after_stall: got %0h expected 5", b_out_data); end
    b_flush   = 1'b1;
    b_in_data = BW'(6); b_in_ctrl = BC'(6);
    tick;
    n_checks++; if (b_out_valid !== 1'b0) begin n_fails++; $display("FAIL s0_flush_valid: got %0b expected 0", b_out_valid); end
    n_checks++; if (b_out_ctrl !== '0) begin n_fails++; $display("FAIL s0_flush_ctrl: got %0h expected 0", b_out_ctrl); end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fails++; $display("FAIL s0_flush_ready: got %0b expected 1", b_in_ready); end
    b_flush    = 1'b0;
    b_in_valid = 1'b0;
    tick;
    n_checks++; if (b_out_data !== BW'(5)) begin n_fails++; $display("FAIL s0_flush_discard: got %0h expected 5", b_out_data); end
    b_in_valid = 1'b1;
    b_in_data  = BW'(16'h77); b_in_ctrl = 11'h7FF;
    tick;
    n_checks++; if (b_out_ctrl !== 11'h7FF) begin n_fails++; $display("FAIL s0_bubble_live: got %0h expected 7ff", b_out_ctrl); end
    b_in_valid = 1'b0;
    tick;
    n_checks++; if (b_out_ctrl !== '0) begin n_fails++; $display("FAIL s0_bubble_nop: got %0h expected 0", b_out_ctrl); end
    n_checks++; if (b_out_data !== BW'(16'h77)) begin n_fails++; $display("FAIL s0_bubble_data: got %0h expected 77", b_out_data); end
    n_checks++; if (b_stall !== 16'd1) begin n_fails++; $display("FAIL s0_stall: got %0d expected 1", b_stall); end
  endtask

  task automatic test_async_reset;
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    c_in_data   = 8'h3C; c_in_ctrl = 4'hA;
    tick;
    n_checks++; if (c_out_data !== 8'h3C) begin n_fails++; $display("FAIL ar_load: got %0h expected 3c", c_out_data); end
    c_in_data = 8'h5D; c_in_ctrl = 4'h5;
    tick;
    n_checks++; if (c_in_ready !== 1'b0) begin n_fails++; $display("FAIL ar_skid_full: got %0b expected 0", c_in_ready); end
    c_in_valid = 1'b0;
    repeat (13) tick;
    n_checks++; if (c_stall !== 4'hE) begin n_fails++; $display("FAIL ar_stall14: got %0h expected e", c_stall); end
    repeat (6) tick;
    n_checks++; if (c_stall !== 4'hF) begin n_fails++; $display("FAIL ar_stall_sat: got %0h expected f", c_stall); end
    n_checks++; if (c_out_data !== 8'h3C) begin n_fails++; $display("FAIL ar_stall_data: got %0h expected 3c", c_out_data); end
    n_checks++; if (c_out_ctrl !== 4'hA) begin n_fails++; $display("FAIL ar_stall_ctrl: got %0h expected a", c_out_ctrl); end
    #3 reset = 1'b1;
    #1;
    n_checks++; if (c_out_valid !== 1'b0) begin n_fails++; $display("FAIL ar_valid: got %0b expected 0", c_out_valid); end
    n_checks++; if (c_out_data !== '0) begin n_fails++; $display("FAIL ar_data: got %0h expected 0", c_out_data); end
    n_checks++; if (c_out_ctrl !== '0) begin n_fails++; $display("FAIL ar_ctrl: got %0h expected 0", c_out_ctrl); end
    n_checks++; if (c_stall !== 4'h0) begin n_fails++; $display("FAIL ar_stall_clr: got %0h expected 0", c_stall); end
    n_checks++; if (c_in_ready !== 1'b0) begin n_fails++; $display("FAIL ar_in_ready: got %0b expected 0", c_in_ready); end
    n_checks++; if (a_out_data !== '0) begin n_fails++; $display("FAIL ar_a_data: got %0h expected 0", a_out_data); end
    tick;
    reset       = 1'b0;
    c_out_ready = 1'b1;
    tick;
    n_checks++; if (c_out_valid !== 1'b0) begin n_fails++; $display("FAIL ar_skid_cleared: got %0b expected 0 data %0h", c_out_valid, c_out_data); end
    n_checks++; if (c_in_ready !== 1'b1) begin n_fails++; $display("FAIL ar_ready_after: got %0b expected 1", c_in_ready); end
  endtask

  initial begin
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0; a_in_ctrl = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0; b_in_ctrl = '0;
    c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = '0; c_in_ctrl = '0;
    test_reset;
    test_stream;
    test_back_to_back;
    test_flush;
    test_bubble;
    test_skid0;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
